// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types, default widths and effective-timing helper for pulse_gen_mc
package pulse_gen_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_PER_W  = 8;
    localparam int TIM_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [TIM_W-1:0] p;
        logic [TIM_W-1:0] w;
    } timing_t;

    // Period floors at 2 so there is always at least one high and one low cycle.
    function automatic timing_t eff_timing(input logic [TIM_W-1:0] period,
                                           input logic [TIM_W-1:0] width);
        timing_t t;
        t.p = (period < TIM_W'(2)) ? TIM_W'(2) : period;
        if (width == '0)
            t.w = TIM_W'(1);
        else if (width >= t.p)
            t.w = t.p - TIM_W'(1);
        else
            t.w = width;
        return t;
    endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// rtl/pulse_gen_ch.sv - single pulse channel: IDLE/HIGH/LOW FSM with phase and burst counters
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [CNT_W-1:0] num,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] width,
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [PER_W-1:0] phase, p_lat, w_lat;
    logic [CNT_W-1:0] rem;
    logic             cont_lat;
    logic             go, last;
    logic             pulse_d, busy_d, done_d;
    timing_t          eff;
    logic [PER_W-1:0] eff_p, eff_w;
    logic             unused_eff_hi;

    always_comb begin
        eff = eff_timing(TIM_W'(period), TIM_W'(width));
    end

    assign eff_p         = eff.p[PER_W-1:0];
    assign eff_w         = eff.w[PER_W-1:0];
    assign unused_eff_hi = ^{eff.p[TIM_W-1:PER_W], eff.w[TIM_W-1:PER_W]};
    assign go            = start && ((num != '0) || cont);
    assign last          = (phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            p_lat    <= '0;
            w_lat    <= '0;
            rem      <= '0;
            cont_lat <= 1'b0;
            pulse    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            pulse <= pulse_d;
            busy  <= busy_d;
            done  <= done_d;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        p_lat    <= eff_p;
                        w_lat    <= eff_w;
                        cont_lat <= cont;
                        rem      <= num;
                        phase    <= eff_w - PER_W'(1);
                    end
                end
                HIGH: phase <= last ? (p_lat - w_lat - PER_W'(1)) : (phase - PER_W'(1));
                LOW: begin
                    if (last) begin
                        phase <= w_lat - PER_W'(1);
                        if (!cont_lat)
                            rem <= rem - CNT_W'(1);
                    end else begin
                        phase <= phase - PER_W'(1);
                    end
                end
                default: phase <= '0;
            endcase
        end
    end

    // rem still counts the pulse just finished, so a value of 1 means this was the last.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (go) state_nxt = HIGH;
            HIGH:    if (last) state_nxt = LOW;
            LOW:     if (last) state_nxt = (cont_lat || (rem != CNT_W'(1))) ? HIGH : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stop)
            state_nxt = IDLE;
    end

    always_comb begin
        pulse_d = (state_nxt == HIGH);
        busy_d  = (state_nxt != IDLE);
        done_d  = (state == LOW) && (state_nxt == IDLE) && !stop;
    end

endmodule

// File: rtl/pulse_gen_mc.sv
// rtl/pulse_gen_mc.sv - multi-channel pulse generator top; PULSE_GEN_MC_IRQ_EN adds sticky done interrupt
module pulse_gen_mc
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PER_W  = DEF_PER_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       cont,
    input  logic [NUM_CH*CNT_W-1:0] num,
    input  logic [NUM_CH*PER_W-1:0] period,
    input  logic [NUM_CH*PER_W-1:0] width,
`ifdef PULSE_GEN_MC_IRQ_EN
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic                    irq,
    output logic [NUM_CH-1:0]       irq_stat,
`endif
    output logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_gen_ch #(
            .CNT_W (CNT_W),
            .PER_W (PER_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .start  (start[i]),
            .stop   (stop[i]),
            .cont   (cont[i]),
            .num    (num[i*CNT_W +: CNT_W]),
            .period (period[i*PER_W +: PER_W]),
            .width  (width[i*PER_W +: PER_W]),
            .pulse  (pulse[i]),
            .busy   (busy[i]),
            .done   (done[i])
        );
    end

`ifdef PULSE_GEN_MC_IRQ_EN
    logic [NUM_CH-1:0] stat_nxt;

    // A done landing in the same cycle as its clear keeps the bit set.
    assign stat_nxt = (irq_stat & ~irq_clr) | done;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_stat <= '0;
            irq      <= 1'b0;
        end else begin
            irq_stat <= stat_nxt;
            irq      <= |stat_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb/tb_pulse_gen_mc.sv - scoreboard bench for pulse_gen_mc
module tb_pulse_gen_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int PER_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       start, stop, cont;
    logic [NUM_CH*CNT_W-1:0] num;
    logic [NUM_CH*PER_W-1:0] period, width;
    logic [NUM_CH-1:0]       pulse, busy, done;
`ifdef PULSE_GEN_MC_IRQ_EN
    logic [NUM_CH-1:0]       irq_clr;
    logic                    irq;
    logic [NUM_CH-1:0]       irq_stat;
`endif

    typedef struct {
        string      tag;
        int         ch;
        int         cyc;
        logic [2:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pulse_gen_mc #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PER_W  (PER_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .cont     (cont),
        .num      (num),
        .period   (period),
        .width    (width),
`ifdef PULSE_GEN_MC_IRQ_EN
        .irq_clr  (irq_clr),
        .irq      (irq),
        .irq_stat (irq_stat),
`endif
        .pulse    (pulse),
        .busy     (busy),
        .done     (done)
    );

    task automatic push(input string tag, input int ch, input int at, input logic [2:0] exp);
        exp_t e;
        int   i = 0;
        e.tag = tag;
        e.ch  = ch;
        e.cyc = at;
        e.exp = exp;
        while (i < q.size() && q[i].cyc <= at) i++;
        q.insert(i, e);
    endtask

    // Expected {pulse, busy, done} for k cycles after the start cycle.
    task automatic push_train(input string tag, input int ch, input int p, input int w, input int len);
        logic hi;
        for (int k = 1; k <= len; k++) begin
            hi = ((k - 1) % p) < w;
            push(tag, ch, cyc + k, {hi, 1'b1, 1'b0});
        end
    endtask

    task automatic push_burst(input string tag, input int ch, input int n, input int p, input int w);
        push_train(tag, ch, p, w, n * p);
        push(tag, ch, cyc + n * p + 1, 3'b001);
    endtask

    task automatic push_idle(input string tag, input int ch, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) push(tag, ch, cyc + k, 3'b000);
    endtask

    task automatic step(input int n);
        exp_t       e;
        logic [2:0] obs;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e   = q.pop_front();
                obs = {pulse[e.ch], busy[e.ch], done[e.ch]};
                tests++;
                assert (obs === e.exp) else begin
                    fails++;
                    $error("FAIL %s ch%0d cyc %0d: observed pbd=%b expected pbd=%b",
                           e.tag, e.ch, e.cyc, obs, e.exp);
                end
            end
        end
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() > 0 && b < 500) begin
            step(1);
            b++;
        end
        tests++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int n, input int p, input int w, input logic c);
        num[ch*CNT_W +: CNT_W]    = CNT_W'(n);
        period[ch*PER_W +: PER_W] = PER_W'(p);
        width[ch*PER_W +: PER_W]  = PER_W'(w);
        cont[ch]                  = c;
    endtask

    initial begin
        rst = 1'b1;
        start = '0; stop = '0; cont = '0;
        num = '0; period = '0; width = '0;
`ifdef PULSE_GEN_MC_IRQ_EN
        irq_clr = '0;
`endif
        step(3);
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) push_idle("reset_idle", c, 1, 20);
        step(20);

        cfg(0, 3, 10, 4, 1'b0);
        start[0] = 1'b1;
        push_burst("burst3", 0, 3, 10, 4);
        push_idle("burst3_after", 0, 32, 34);
        step(1);
        start = '0;
        drain();

        cfg(1, 0, 5, 2, 1'b1);
        start[1] = 1'b1;
        push_train("cont", 1, 5, 2, 23);
        push_idle("cont_stop", 1, 24, 30);
        step(1);
        start = '0;
        step(22);
        stop[1] = 1'b1;
        step(1);
        stop = '0;
        drain();

        cfg(1, 0, 5, 2, 1'b0);
        start[1] = 1'b1;
        push_idle("num0_ignored", 1, 1, 6);
        step(1);
        start = '0;
        drain();

        cfg(2, 2, 1, 0, 1'b0);
        start[2] = 1'b1;
        push_burst("clamp_p1w0", 2, 2, 2, 1);
        push_idle("clamp_p1w0_after", 2, 6, 7);
        step(1);
        start = '0;
        drain();

        cfg(2, 1, 6, 9, 1'b0);
        start[2] = 1'b1;
        push_burst("clamp_w9", 2, 1, 6, 5);
        push_idle("clamp_w9_after", 2, 8, 9);
        step(1);
        start = '0;
        drain();

        cfg(0, 2, 4, 1, 1'b0);
        cfg(3, 1, 7, 3, 1'b0);
        start = 4'b1001;
        push_burst("pair_ch0", 0, 2, 4, 1);
        push_burst("pair_ch3", 3, 1, 7, 3);
        push_idle("pair_ch1", 1, 1, 9);
        push_idle("pair_ch2", 2, 1, 9);
        step(1);
        start = '0;
        step(2);
        cfg(0, 5, 3, 2, 1'b1);
        start[0] = 1'b1;
        step(1);
        start = '0;
        drain();

        cfg(0, 1, 3, 1, 1'b0);
        start[0] = 1'b1;
        push_burst("restart_first", 0, 1, 3, 1);
        step(1);
        start = '0;
        step(3);
        cfg(0, 1, 2, 1, 1'b0);
        start[0] = 1'b1;
        push_burst("restart_in_done", 0, 1, 2, 1);
        step(1);
        start = '0;
        drain();

        cfg(0, 3, 10, 4, 1'b0);
        cfg(3, 0, 5, 2, 1'b1);
        start = 4'b1001;
        push_train("rst_mid_ch0", 0, 10, 4, 7);
        push_train("rst_mid_ch3", 3, 5, 2, 7);
        for (int c = 0; c < NUM_CH; c++) push_idle("after_rst", c, 8, 10);
        step(1);
        start = '0;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        drain();

`ifdef PULSE_GEN_MC_IRQ_EN
        check("irq_reset", {31'd0, irq}, 32'd0);
        check("irq_stat_reset", 32'(irq_stat), 32'd0);
        cfg(2, 1, 2, 1, 1'b0);
        start[2] = 1'b1;
        push_burst("irq_burst", 2, 1, 2, 1);
        step(1);
        start = '0;
        step(2);
        check("irq_stat_before_set", 32'(irq_stat), 32'd0);
        step(1);
        check("irq_stat_set", 32'(irq_stat), 32'h4);
        check("irq_set", {31'd0, irq}, 32'd1);
        step(2);
        check("irq_stat_sticky", 32'(irq_stat), 32'h4);
        irq_clr = 4'b0100;
        step(1);
        irq_clr = '0;
        check("irq_stat_cleared", 32'(irq_stat), 32'd0);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        start[2] = 1'b1;
        push_burst("irq_burst2", 2, 1, 2, 1);
        step(1);
        start = '0;
        step(2);
        irq_clr = 4'b0100;
        step(1);
        irq_clr = '0;
        check("irq_set_wins", 32'(irq_stat), 32'h4);
        check("irq_set_wins_irq", {31'd0, irq}, 32'd1);
        irq_clr = 4'b0100;
        step(1);
        irq_clr = '0;
        check("irq_final_clear", {31'd0, irq}, 32'd0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
